// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle RV32I control FSM. Fetches one instruction at a time and
// sequences decode, ALU, data memory, writeback, PC update and trap entry.
module exec_sequencer #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        irq,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        dec_en,
  output logic [31:0] instr_q,
  input  logic        invalid,
  input  logic [8:0]  mem_op,
  input  logic [7:0]  mechie_op,
  input  logic        br_taken,
  output logic        alu_en,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        trap_valid,
  output logic [3:0]  trap_cause,
  output logic        busy,
  output logic [31:0] instret
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WFI    = 3'd5;
  localparam logic [2:0] S_WB     = 3'd6;
  localparam logic [2:0] S_TRAP   = 3'd7;

  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;

  // The counter holds the number of ack-less cycles already elapsed, so the
  // TIMEOUT-th waiting cycle is the one where it reads TIMEOUT-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [3:0]       cause_nxt;
  logic [CNT_W-1:0] cnt;
  logic             is_store;
  logic             is_ret;
  logic             take;
  logic [4:0]       opcode;
  logic             timed_out;
  logic             unused_ok;

  assign opcode    = instr_q[6:2];
  assign timed_out = (cnt == CNT_LAST);
  assign unused_ok = ^{mechie_op[7:6], mechie_op[3], mem_op[0]};

  always_comb begin
    state_nxt = state;
    cause_nxt = trap_cause;
    case (state)
      S_IDLE: begin
        if (run) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          state_nxt = S_DECODE;
        end else if (timed_out) begin
          state_nxt = S_TRAP;
          cause_nxt = 4'd1;
        end
      end
      S_DECODE: begin
        if (invalid) begin
          state_nxt = S_TRAP;
          cause_nxt = 4'd2;
        end else begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (mechie_op[1]) begin
          state_nxt = S_TRAP;
          cause_nxt = 4'd11;
        end else if (mechie_op[0]) begin
          state_nxt = S_TRAP;
          cause_nxt = 4'd3;
        end else if (mechie_op[5]) begin
          state_nxt = S_WFI;
        end else if (|mem_op[8:1]) begin
          state_nxt = S_MEM;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          state_nxt = S_WB;
        end else if (timed_out) begin
          state_nxt = S_TRAP;
          cause_nxt = is_store ? 4'd7 : 4'd5;
        end
      end
      S_WFI: begin
        if (irq) state_nxt = S_WB;
      end
      S_WB, S_TRAP: begin
        state_nxt = run ? S_FETCH : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      instr_q    <= 32'd0;
      trap_cause <= 4'd0;
      instret    <= 32'd0;
      is_store   <= 1'b0;
      is_ret     <= 1'b0;
      take       <= 1'b0;
    end else begin
      state      <= state_nxt;
      trap_cause <= cause_nxt;
      if (state == S_FETCH && imem_ack) instr_q <= imem_rdata;
      if ((state == S_FETCH || state == S_MEM) && state_nxt == state) cnt <= cnt + 1'b1;
      else cnt <= '0;
      if (state == S_EXEC) begin
        is_store <= |mem_op[8:6];
        is_ret   <= mechie_op[2] | mechie_op[4];
        take     <= (opcode == OP_JAL) || (opcode == OP_JALR) ||
                    ((opcode == OP_BRANCH) && br_taken);
      end
      if (state == S_WB) instret <= instret + 32'd1;
    end
  end

  assign imem_req   = (state == S_FETCH);
  assign dec_en     = (state == S_DECODE);
  assign alu_en     = (state == S_EXEC);
  assign dmem_req   = (state == S_MEM);
  assign dmem_we    = (state == S_MEM) && is_store;
  assign pc_we      = (state == S_WB) || (state == S_TRAP);
  assign trap_valid = (state == S_TRAP);
  assign busy       = (state != S_IDLE);
  assign rf_we      = (state == S_WB) && (opcode != OP_BRANCH) && (opcode != OP_STORE) &&
                      (instr_q[11:7] != 5'd0);

  always_comb begin
    pc_sel = 2'd0;
    if (state == S_TRAP) begin
      pc_sel = 2'd2;
    end else if (state == S_WB) begin
      if (is_ret) pc_sel = 2'd3;
      else if (take) pc_sel = 2'd1;
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Testbench for exec_sequencer: a directed vector table plus a randomized instruction
// stream, each instruction checked against an outcome and cycle-count model.
module tb_exec_sequencer;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        irq;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dec_en;
  logic [31:0] instr_q;
  logic        invalid;
  logic [8:0]  mem_op;
  logic [7:0]  mechie_op;
  logic        br_taken;
  logic        alu_en;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        rf_we;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        trap_valid;
  logic [3:0]  trap_cause;
  logic        busy;
  logic [31:0] instret;

  always #5 clk = ~clk;

  exec_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .irq(irq),
    .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dec_en(dec_en), .instr_q(instr_q), .invalid(invalid), .mem_op(mem_op),
    .mechie_op(mechie_op), .br_taken(br_taken), .alu_en(alu_en),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel), .trap_valid(trap_valid),
    .trap_cause(trap_cause), .busy(busy), .instret(instret)
  );

  typedef struct {
    logic [31:0] instr;
    logic        invalid;
    logic [8:0]  mem_op;
    logic [7:0]  mechie_op;
    logic        br_taken;
    int          imem_wait;
    int          dmem_wait;
    int          irq_wait;
    logic        run_after;
    int          exp_cycles;
    logic        exp_trap;
    logic [3:0]  exp_cause;
    logic [1:0]  exp_pc_sel;
    logic        exp_rf_we;
    logic        exp_dmem_we;
  } vec_t;

  int          tests = 0;
  int          failed = 0;
  logic [31:0] exp_instret = 32'd0;
  vec_t        dir_vecs[16];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] instr, input logic inv, input logic [8:0] mop,
                              input logic [7:0] mech, input logic br, input int iw, input int dw,
                              input int qw, input logic ra, input int cyc, input logic trap,
                              input logic [3:0] cause, input logic [1:0] sel, input logic rfwe,
                              input logic dwe);
    vec_t v;
    v.instr = instr; v.invalid = inv; v.mem_op = mop; v.mechie_op = mech; v.br_taken = br;
    v.imem_wait = iw; v.dmem_wait = dw; v.irq_wait = qw; v.run_after = ra;
    v.exp_cycles = cyc; v.exp_trap = trap; v.exp_cause = cause; v.exp_pc_sel = sel;
    v.exp_rf_we = rfwe; v.exp_dmem_we = dwe;
    return v;
  endfunction

  // Outcome model: latency is the sum of phase lengths, result follows the class rules.
  function automatic vec_t model(input vec_t v);
    vec_t       r;
    int         fetch_cycles;
    int         middle;
    logic [4:0] opc;
    logic       is_mem;
    logic       store;
    r = v;
    opc = v.instr[6:2];
    is_mem = |v.mem_op[8:1];
    store = |v.mem_op[8:6];
    middle = 0;
    r.exp_trap = 1'b0; r.exp_cause = 4'd0; r.exp_pc_sel = 2'd0;
    r.exp_rf_we = 1'b0; r.exp_dmem_we = 1'b0;
    fetch_cycles = v.imem_wait + 1;
    if (v.imem_wait >= TIMEOUT) begin
      r.exp_cycles = TIMEOUT + 1; r.exp_trap = 1'b1; r.exp_cause = 4'd1; r.exp_pc_sel = 2'd2;
    end else if (v.invalid) begin
      r.exp_cycles = fetch_cycles + 2; r.exp_trap = 1'b1; r.exp_cause = 4'd2; r.exp_pc_sel = 2'd2;
    end else if (v.mechie_op[1]) begin
      r.exp_cycles = fetch_cycles + 3; r.exp_trap = 1'b1; r.exp_cause = 4'd11; r.exp_pc_sel = 2'd2;
    end else if (v.mechie_op[0]) begin
      r.exp_cycles = fetch_cycles + 3; r.exp_trap = 1'b1; r.exp_cause = 4'd3; r.exp_pc_sel = 2'd2;
    end else if (!v.mechie_op[5] && is_mem && v.dmem_wait >= TIMEOUT) begin
      r.exp_cycles = fetch_cycles + 2 + TIMEOUT + 1; r.exp_trap = 1'b1;
      r.exp_cause = store ? 4'd7 : 4'd5; r.exp_pc_sel = 2'd2; r.exp_dmem_we = store;
    end else begin
      if (v.mechie_op[5]) begin
        middle = v.irq_wait + 1;
      end else if (is_mem) begin
        middle = v.dmem_wait + 1;
        r.exp_dmem_we = store;
      end
      r.exp_cycles = fetch_cycles + 2 + middle + 1;
      if (v.mechie_op[2] || v.mechie_op[4]) r.exp_pc_sel = 2'd3;
      else if (opc == 5'b11011 || opc == 5'b11001 || (opc == 5'b11000 && v.br_taken)) r.exp_pc_sel = 2'd1;
      r.exp_rf_we = (opc != 5'b11000) && (opc != 5'b01000) && (v.instr[11:7] != 5'd0);
    end
    return r;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    int   kind;
    int   bitpos;
    v.instr = $urandom; v.invalid = 1'b0; v.mem_op = 9'd0; v.mechie_op = 8'd0;
    v.br_taken = 1'($urandom_range(0, 1));
    v.imem_wait = int'($urandom_range(0, 5));
    v.dmem_wait = int'($urandom_range(0, 5));
    v.irq_wait = int'($urandom_range(0, 6));
    v.run_after = ($urandom_range(0, 3) != 0);
    kind = int'($urandom_range(0, 12));
    case (kind)
      0: v.instr[6:0] = 7'b0010011;
      1: v.instr[6:0] = 7'b0110011;
      2: begin v.instr[6:0] = 7'b0000011; bitpos = int'($urandom_range(1, 5)); v.mem_op[bitpos] = 1'b1; end
      3: begin v.instr[6:0] = 7'b0100011; bitpos = int'($urandom_range(6, 8)); v.mem_op[bitpos] = 1'b1; end
      4: v.instr[6:0] = 7'b1100011;
      5: v.instr[6:0] = 7'b1101111;
      6: v.instr[6:0] = 7'b1100111;
      7: begin v.instr = 32'h00000073; v.mechie_op[1] = 1'b1; end
      8: begin v.instr = 32'h00100073; v.mechie_op[0] = 1'b1; end
      9: begin v.instr = 32'h10500073; v.mechie_op[5] = 1'b1; end
      10: begin
        if ($urandom_range(0, 1) != 0) begin v.instr = 32'h30200073; v.mechie_op[2] = 1'b1; end
        else begin v.instr = 32'h10200073; v.mechie_op[4] = 1'b1; end
      end
      12: begin v.instr[6:0] = 7'b0110111; v.mem_op[0] = 1'b1; end
      default: begin
        v.invalid = 1'b1; v.mem_op = 9'($urandom); v.mechie_op = 8'($urandom);
      end
    endcase
    return v;
  endfunction

  // Drives one instruction through the bus handshakes and compares its observed outcome.
  task automatic apply_stimulus(input int idx, input vec_t v);
    int         cyc, guard, fetch_n, mem_n, wfi_n, dec_at, alu_at, dec_n, alu_n;
    logic       started, seen_alu, done, saw_dwe, trap_o, rfwe_o;
    logic [1:0] sel_o;
    logic [3:0] cause_o;
    cyc = 0; guard = 0; fetch_n = 0; mem_n = 0; wfi_n = 0;
    dec_at = 0; alu_at = 0; dec_n = 0; alu_n = 0;
    started = 1'b0; seen_alu = 1'b0; done = 1'b0; saw_dwe = 1'b0; trap_o = 1'b0; rfwe_o = 1'b0;
    sel_o = 2'd0; cause_o = 4'd0;
    invalid = v.invalid; mem_op = v.mem_op; mechie_op = v.mechie_op; br_taken = v.br_taken;
    while (!done && guard < 300) begin
      guard++;
      if (imem_req) started = 1'b1;
      if (started) cyc++;
      run = started ? v.run_after : 1'b1;
      irq = 1'($urandom_range(0, 1));
      if (imem_req) begin
        imem_ack = (v.imem_wait < TIMEOUT) && (fetch_n == v.imem_wait);
        imem_rdata = imem_ack ? v.instr : $urandom;
        fetch_n++;
      end else begin
        imem_ack = 1'($urandom_range(0, 1));
        imem_rdata = $urandom;
      end
      if (dmem_req) begin
        dmem_ack = (mem_n == v.dmem_wait);
        saw_dwe = saw_dwe | dmem_we;
        mem_n++;
      end else begin
        dmem_ack = 1'($urandom_range(0, 1));
      end
      if (dec_en) begin dec_n++; dec_at = cyc; end
      if (alu_en) begin
        alu_n++; alu_at = cyc; seen_alu = 1'b1;
      end else if (seen_alu && v.mechie_op[5] && !pc_we) begin
        irq = (wfi_n == v.irq_wait);
        wfi_n++;
      end
      if (pc_we) begin
        done = 1'b1; sel_o = pc_sel; rfwe_o = rf_we; trap_o = trap_valid; cause_o = trap_cause;
      end
      @(negedge clk);
    end
    check_output($sformatf("v%0d completes", idx), done, 1);
    check_output($sformatf("v%0d cycles", idx), cyc, v.exp_cycles);
    check_output($sformatf("v%0d trap_valid", idx), trap_o, v.exp_trap);
    if (v.exp_trap) check_output($sformatf("v%0d trap_cause", idx), cause_o, v.exp_cause);
    check_output($sformatf("v%0d pc_sel", idx), sel_o, v.exp_pc_sel);
    check_output($sformatf("v%0d rf_we", idx), rfwe_o, v.exp_rf_we);
    check_output($sformatf("v%0d dmem_we", idx), saw_dwe, v.exp_dmem_we);
    if (v.imem_wait < TIMEOUT) begin
      check_output($sformatf("v%0d instr_q", idx), instr_q, v.instr);
      check_output($sformatf("v%0d dec_en cycle", idx), dec_at, v.imem_wait + 2);
      check_output($sformatf("v%0d dec_en pulses", idx), dec_n, 1);
      if (!v.invalid) check_output($sformatf("v%0d alu_en cycle", idx), alu_at, v.imem_wait + 3);
      check_output($sformatf("v%0d alu_en pulses", idx), alu_n, v.invalid ? 0 : 1);
    end else begin
      check_output($sformatf("v%0d dec_en pulses", idx), dec_n, 0);
    end
    if (!v.exp_trap) exp_instret = exp_instret + 32'd1;
    check_output($sformatf("v%0d instret", idx), instret, exp_instret);
    check_output($sformatf("v%0d busy after", idx), busy, v.run_after);
    check_output($sformatf("v%0d pc_we pulse", idx), pc_we, 0);
  endtask

  initial begin
    int guard;
    rst_n = 1'b0; run = 1'b0; irq = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0;
    invalid = 1'b0; mem_op = 9'd0; mechie_op = 8'd0; br_taken = 1'b0; dmem_ack = 1'b0;

    //                instr         inv mem_op  mech   br iw  dw  qw  ra cyc trap cause sel rfwe dwe
    dir_vecs[0]  = mk(32'h00100093, 0, 9'h000, 8'h00, 0, 0,  0,  0,  1, 4,  0,   0,    0,  1,   0);
    dir_vecs[1]  = mk(32'h0000A103, 0, 9'h008, 8'h00, 0, 0,  3,  0,  1, 8,  0,   0,    0,  1,   0);
    dir_vecs[2]  = mk(32'h00208463, 0, 9'h000, 8'h00, 1, 0,  0,  0,  1, 4,  0,   0,    1,  0,   0);
    dir_vecs[3]  = mk(32'h00208463, 0, 9'h000, 8'h00, 0, 0,  0,  0,  1, 4,  0,   0,    0,  0,   0);
    dir_vecs[4]  = mk(32'hFFFFFFFF, 1, 9'h000, 8'h00, 0, 0,  0,  0,  1, 3,  1,   2,    2,  0,   0);
    dir_vecs[5]  = mk(32'h00000073, 0, 9'h000, 8'h02, 0, 0,  0,  0,  1, 4,  1,   11,   2,  0,   0);
    dir_vecs[6]  = mk(32'h00100073, 0, 9'h000, 8'h01, 0, 0,  0,  0,  1, 4,  1,   3,    2,  0,   0);
    dir_vecs[7]  = mk(32'h00100093, 0, 9'h000, 8'h00, 0, 99, 0,  0,  1, 5,  1,   1,    2,  0,   0);
    dir_vecs[8]  = mk(32'h00100093, 0, 9'h000, 8'h00, 0, 3,  0,  0,  1, 7,  0,   0,    0,  1,   0);
    dir_vecs[9]  = mk(32'h10500073, 0, 9'h000, 8'h20, 0, 0,  0,  10, 1, 15, 0,   0,    0,  0,   0);
    dir_vecs[10] = mk(32'h0020A023, 0, 9'h100, 8'h00, 0, 0,  0,  0,  0, 5,  0,   0,    0,  0,   1);
    dir_vecs[11] = mk(32'h0000A103, 0, 9'h008, 8'h00, 0, 0,  99, 0,  1, 8,  1,   5,    2,  0,   0);
    dir_vecs[12] = mk(32'h0020A023, 0, 9'h100, 8'h00, 0, 0,  99, 0,  1, 8,  1,   7,    2,  0,   1);
    dir_vecs[13] = mk(32'h30200073, 0, 9'h000, 8'h04, 0, 0,  0,  0,  1, 4,  0,   0,    3,  0,   0);
    dir_vecs[14] = mk(32'h008000EF, 0, 9'h000, 8'h00, 0, 0,  0,  0,  1, 4,  0,   0,    1,  1,   0);
    dir_vecs[15] = mk(32'h000052B7, 0, 9'h001, 8'h00, 0, 0,  0,  0,  0, 4,  0,   0,    0,  1,   0);

    repeat (3) @(negedge clk);
    check_output("reset busy", busy, 0);
    check_output("reset imem_req", imem_req, 0);
    check_output("reset strobes", {dec_en, alu_en, dmem_req, dmem_we, rf_we, pc_we, trap_valid}, 0);
    check_output("reset pc_sel", pc_sel, 0);
    check_output("reset trap_cause", trap_cause, 0);
    check_output("reset instret", instret, 0);
    check_output("reset instr_q", instr_q, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_output("idle without run", busy, 0);

    for (int i = 0; i < 16; i++) apply_stimulus(i, dir_vecs[i]);
    for (int i = 0; i < 60; i++) apply_stimulus(100 + i, model(rand_vec()));

    // Asynchronous reset while a fetch is outstanding must drop the request at once.
    run = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; irq = 1'b0;
    guard = 0;
    while (!imem_req && guard < 5) begin
      @(negedge clk);
      guard++;
    end
    check_output("fetch before reset", imem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check_output("async reset imem_req", imem_req, 0);
    check_output("async reset busy", busy, 0);
    check_output("async reset instret", instret, 0);
    exp_instret = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(200, dir_vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
